// File: rtl/trig_out_pulser.sv
// Multi-channel trigger output pulser: per-channel delay/width/dead FSMs with
// registered outputs, plus sticky per-channel miss flags and a shared drop counter.

module trig_out_chan #(
  parameter int DELAY_W = 8,
  parameter int WIDTH_W = 8,
  parameter int DEAD_W  = 8,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               fire,
  input  logic [DELAY_W-1:0] delay,
  input  logic [WIDTH_W-1:0] width,
  input  logic [DEAD_W-1:0]  dead,
  output logic               out,
  output logic               busy,
  output logic               drop
);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_HIGH, S_DEAD} state_t;

  // Pulse shape captured at accept so later config edits cannot reshape it.
  typedef struct packed {
    logic [WIDTH_W-1:0] width;
    logic [DEAD_W-1:0]  dead;
  } cfg_t;

  state_t            st, st_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  cfg_t              cfg, cfg_nx;
  logic              out_q;
  logic              accept;
  logic [CNT_W-1:0]  wm1_in, wm1_q;

  assign accept = en & fire & (st == S_IDLE);
  assign drop   = en & fire & (st != S_IDLE);
  assign busy   = (st != S_IDLE);
  assign out    = out_q;

  // High time is max(width,1), so the loaded count is max(width,1)-1.
  assign wm1_in = (width == '0)     ? '0 : CNT_W'(width)     - CNT_W'(1);
  assign wm1_q  = (cfg.width == '0) ? '0 : CNT_W'(cfg.width) - CNT_W'(1);

  always_comb begin
    st_nx  = st;
    cnt_nx = cnt;
    cfg_nx = cfg;
    case (st)
      S_IDLE: if (accept) begin
        cfg_nx.width = width;
        cfg_nx.dead  = dead;
        if (delay != '0) begin
          st_nx  = S_DELAY;
          cnt_nx = CNT_W'(delay) - CNT_W'(1);
        end else begin
          st_nx  = S_HIGH;
          cnt_nx = wm1_in;
        end
      end
      S_DELAY: if (cnt == '0) begin
        st_nx  = S_HIGH;
        cnt_nx = wm1_q;
      end else cnt_nx = cnt - CNT_W'(1);
      S_HIGH: if (cnt == '0) begin
        if (cfg.dead != '0) begin
          st_nx  = S_DEAD;
          cnt_nx = CNT_W'(cfg.dead) - CNT_W'(1);
        end else st_nx = S_IDLE;
      end else cnt_nx = cnt - CNT_W'(1);
      S_DEAD: if (cnt == '0) st_nx = S_IDLE;
              else cnt_nx = cnt - CNT_W'(1);
      default: st_nx = S_IDLE;
    endcase
  end

  // out is registered from the next state so the pin sees a bare flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= S_IDLE;
      cnt   <= '0;
      cfg   <= '0;
      out_q <= 1'b0;
    end else begin
      st    <= st_nx;
      cnt   <= cnt_nx;
      cfg   <= cfg_nx;
      out_q <= (st_nx == S_HIGH);
    end
  end

endmodule

module trig_out_pulser #(
  parameter int CHANNELS = 8,
  parameter int DELAY_W  = 8,
  parameter int WIDTH_W  = 8,
  parameter int DEAD_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [CHANNELS-1:0] fire,
  input  logic [DELAY_W-1:0]  delay,
  input  logic [WIDTH_W-1:0]  width,
  input  logic [DEAD_W-1:0]   dead,
  input  logic                clr_miss,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] miss,
  output logic [15:0]         miss_cnt
);

  localparam int DW_MAX = (DELAY_W > WIDTH_W) ? DELAY_W : WIDTH_W;
  localparam int CNT_W  = (DW_MAX > DEAD_W) ? DW_MAX : DEAD_W;

  logic [CHANNELS-1:0] drops;
  logic [15:0]         ndrop, base, cnt_nx;
  logic [16:0]         sum;

  trig_out_chan #(
    .DELAY_W(DELAY_W), .WIDTH_W(WIDTH_W), .DEAD_W(DEAD_W), .CNT_W(CNT_W)
  ) u_ch [CHANNELS-1:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .fire  (fire),
    .delay (delay),
    .width (width),
    .dead  (dead),
    .out   (out),
    .busy  (busy),
    .drop  (drops)
  );

  // Clear first, then add this cycle's drops: a drop in a clear cycle survives.
  always_comb begin
    ndrop = '0;
    for (int i = 0; i < CHANNELS; i++) ndrop = ndrop + 16'(drops[i]);
    base   = clr_miss ? 16'h0 : miss_cnt;
    sum    = {1'b0, base} + {1'b0, ndrop};
    cnt_nx = sum[16] ? 16'hFFFF : sum[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss     <= '0;
      miss_cnt <= '0;
    end else begin
      miss     <= (clr_miss ? '0 : miss) | drops;
      miss_cnt <= cnt_nx;
    end
  end

endmodule
